// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM write-side arbitration logic.
package sram_pkg;

  // Default beat width of the write_interface data bus.
  localparam int SRAM_DATA_W = 8;

  // Packet-level arbiter state: waiting for a sop request, or holding a grant.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. Searches req from ptr+1 upward, wrapping at
// NUM_PORTS, and returns the first requester as one-hot gnt and binary idx.
// gnt is all-zero when nothing requests. Also used by the read-side arbiter.
module rr_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]         gnt,
  output logic [$clog2(NUM_PORTS)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the ports in priority order starting just after the last winner.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_PORTS);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/sram_wr_arbiter.sv
// Packet-level round-robin arbiter sharing the SRAM write port among NUM_PORTS
// write_interface requesters. A grant is taken on a sop request and held until
// the eop beat transfers, so packets are never interleaved.
// Optional: define SRAM_WR_ARB_STATS_EN to add per-port 16-bit eop counters on pkt_cnt.
module sram_wr_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = SRAM_DATA_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]         in_sop,
  input  logic [NUM_PORTS-1:0]         in_eop,
  output logic [NUM_PORTS-1:0]         in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  input  logic                         out_ready,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic                         err_sop
`ifdef SRAM_WR_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]      pkt_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             first_q, first_d;   // next transfer is the packet's first beat
  logic             err_sop_q, err_sop_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] rr_gnt;
  logic [IDX_W-1:0]     rr_idx;
  logic [DATA_W-1:0]    port_data [NUM_PORTS];
  logic                 xfer;

  // Only a beat carrying sop may open a new packet.
  assign req = in_valid & in_sop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign port_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Pass-through of the granted port while busy; everything quiet while idle.
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    if (state_q == ARB_BUSY) begin
      out_valid            = in_valid[grant_id_q];
      out_data             = port_data[grant_id_q];
      out_sop              = in_sop[grant_id_q];
      out_eop              = in_eop[grant_id_q];
      in_ready[grant_id_q] = out_ready;
    end
  end

  assign xfer = out_valid & out_ready;

  // Next state: grant on a sop request, release on the eop transfer.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    first_d    = first_q;
    err_sop_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|rr_gnt) begin
          grant_id_d = rr_idx;
          first_d    = 1'b1;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (xfer) begin
          first_d   = 1'b0;
          // A sop after the opening beat is flagged but still forwarded.
          err_sop_d = out_sop & ~first_q;
          if (out_eop) begin
            ptr_d   = grant_id_q;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      ptr_q      <= IDX_W'(NUM_PORTS - 1);
      first_q    <= 1'b0;
      err_sop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      first_q    <= first_d;
      err_sop_q  <= err_sop_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == ARB_BUSY);
  assign err_sop  = err_sop_q;

`ifdef SRAM_WR_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
      logic [15:0] cnt_q, cnt_d;

      // Count completed packets of this port; wraps naturally at 16 bits.
      always_comb begin
        cnt_d = cnt_q;
        if (xfer && out_eop && (grant_id_q == IDX_W'(gi))) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Per-port packet counter register.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign pkt_cnt[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule
